// File: rtl/vend_txn_controller_if.sv
// Purchase-path bus between the coin/keypad front end and vend_txn_controller.
// The master side drives coins, selections, inventory/price vectors and change_ack.
interface vend_txn_controller_if;
  logic        coin_valid;
  logic [3:0]  coin_value;
  logic        select_valid;
  logic [2:0]  select_type;
  logic [3:0]  select_qty;
  logic        cancel;
  logic [19:0] all_number;
  logic [19:0] all_price;
  logic        change_ack;
  logic [7:0]  credit;
  logic [11:0] saved_money;
  logic [19:0] update_all_number;
  logic        vend_valid;
  logic [2:0]  vend_type;
  logic [3:0]  vend_qty;
  logic        change_valid;
  logic [7:0]  change_amount;
  logic        error;
  logic [1:0]  err_code;
  logic [2:0]  state;

  modport master (
    output coin_valid, coin_value, select_valid, select_type, select_qty, cancel,
           all_number, all_price, change_ack,
    input  credit, saved_money, update_all_number, vend_valid, vend_type, vend_qty,
           change_valid, change_amount, error, err_code, state
  );

  modport slave (
    input  coin_valid, coin_value, select_valid, select_type, select_qty, cancel,
           all_number, all_price, change_ack,
    output credit, saved_money, update_all_number, vend_valid, vend_type, vend_qty,
           change_valid, change_amount, error, err_code, state
  );
endinterface

// File: rtl/vend_txn_controller.sv
// Multi-cycle, cancellable vending purchase sequencer: credit -> check -> vend -> change.
// Optional CREDIT idle-timeout refund enabled by defining VEND_TIMEOUT_EN.
module vend_txn_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input logic clk,
  input logic reset,
  vend_txn_controller_if.slave bus
);

  // Handshake: change_valid rises with change_amount and both hold until the
  // edge on which change_ack is sampled high; vend_valid and error are
  // single-cycle pulses with no back-pressure.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CREDIT = 3'd1,
    CHECK  = 3'd2,
    VEND   = 3'd3,
    CHANGE = 3'd4
  } state_t;

  state_t      state_q;
  logic [7:0]  credit_q;
  logic [11:0] saved_q;
  logic [2:0]  type_q;
  logic [3:0]  qty_q;
  logic [7:0]  cost_q;
  logic        vend_valid_q;
  logic        change_valid_q;
  logic [7:0]  change_amount_q;
  logic        error_q;
  logic [1:0]  err_code_q;

  logic [3:0]  price_sel;
  logic [3:0]  stock_sel;
  logic        type_ok;
  logic [7:0]  cost;
  logic [8:0]  coin_sum;
  logic [12:0] saved_sum;
  logic [19:0] upd_number;

  always_comb begin
    price_sel = 4'd0;
    stock_sel = 4'd0;
    type_ok   = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (type_q == 3'(k)) begin
        price_sel = bus.all_price[4*k-4 +: 4];
        stock_sel = bus.all_number[4*k-4 +: 4];
        type_ok   = 1'b1;
      end
    end
  end

  assign cost      = {4'd0, qty_q} * {4'd0, price_sel};
  assign coin_sum  = {1'b0, credit_q} + {5'd0, bus.coin_value};
  assign saved_sum = {1'b0, saved_q} + {5'd0, cost_q};

  // Only the latched product's field changes, and only during the VEND cycle.
  always_comb begin
    upd_number = bus.all_number;
    if (state_q == VEND) begin
      for (int k = 1; k <= 5; k++) begin
        if (type_q == 3'(k)) upd_number[4*k-4 +: 4] = stock_sel - qty_q;
      end
    end
  end

`ifdef VEND_TIMEOUT_EN
  logic [15:0] idle_cnt;
  logic        timeout_hit;
  assign timeout_hit = (idle_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      credit_q        <= 8'd0;
      saved_q         <= 12'd0;
      type_q          <= 3'd0;
      qty_q           <= 4'd0;
      cost_q          <= 8'd0;
      vend_valid_q    <= 1'b0;
      change_valid_q  <= 1'b0;
      change_amount_q <= 8'd0;
      error_q         <= 1'b0;
      err_code_q      <= 2'd0;
`ifdef VEND_TIMEOUT_EN
      idle_cnt        <= 16'd0;
`endif
    end else begin
      error_q      <= 1'b0;
      vend_valid_q <= 1'b0;
`ifdef VEND_TIMEOUT_EN
      idle_cnt     <= 16'd0;
`endif
      case (state_q)
        IDLE: begin
          if (bus.coin_valid) begin
            credit_q <= coin_sum[7:0];
            state_q  <= CREDIT;
          end
        end
        CREDIT: begin
          if (bus.select_valid) begin
            type_q  <= bus.select_type;
            qty_q   <= bus.select_qty;
            state_q <= CHECK;
            if (bus.coin_valid) begin
              error_q    <= 1'b1;
              err_code_q <= 2'd3;
            end
          end else if (bus.cancel) begin
            state_q         <= CHANGE;
            change_valid_q  <= 1'b1;
            change_amount_q <= credit_q;
            if (bus.coin_valid) begin
              error_q    <= 1'b1;
              err_code_q <= 2'd3;
            end
          end else if (bus.coin_valid) begin
            if (coin_sum[8]) begin
              error_q    <= 1'b1;
              err_code_q <= 2'd3;
            end else begin
              credit_q <= coin_sum[7:0];
            end
`ifdef VEND_TIMEOUT_EN
          end else if (timeout_hit) begin
            state_q         <= CHANGE;
            change_valid_q  <= 1'b1;
            change_amount_q <= credit_q;
          end else begin
            idle_cnt <= idle_cnt + 16'd1;
`endif
          end
        end
        CHECK: begin
          cost_q <= cost;
          if (!type_ok || qty_q == 4'd0 || stock_sel < qty_q) begin
            error_q    <= 1'b1;
            err_code_q <= 2'd1;
            state_q    <= CREDIT;
          end else if (cost > credit_q) begin
            error_q    <= 1'b1;
            err_code_q <= 2'd2;
            state_q    <= CREDIT;
          end else begin
            vend_valid_q <= 1'b1;
            state_q      <= VEND;
          end
        end
        VEND: begin
          credit_q <= credit_q - cost_q;
          saved_q  <= saved_sum[12] ? 12'hFFF : saved_sum[11:0];
          if (credit_q != cost_q) begin
            state_q         <= CHANGE;
            change_valid_q  <= 1'b1;
            change_amount_q <= credit_q - cost_q;
          end else begin
            state_q <= IDLE;
          end
        end
        CHANGE: begin
          if (bus.coin_valid) begin
            error_q    <= 1'b1;
            err_code_q <= 2'd3;
          end
          if (bus.change_ack) begin
            credit_q       <= 8'd0;
            change_valid_q <= 1'b0;
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.credit            = credit_q;
  assign bus.saved_money       = saved_q;
  assign bus.update_all_number = upd_number;
  assign bus.vend_valid        = vend_valid_q;
  assign bus.vend_type         = type_q;
  assign bus.vend_qty          = qty_q;
  assign bus.change_valid      = change_valid_q;
  assign bus.change_amount     = change_amount_q;
  assign bus.error             = error_q;
  assign bus.err_code          = err_code_q;
  assign bus.state             = state_q;

endmodule
